// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared constants and types for the BCD calculator keypad
//             entry path: key codes, controller state encoding, display
//             select codes and the 4-digit BCD operand type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

  // Key codes delivered by the debouncer; 0-9 are digits, 15 is unused.
  localparam logic [3:0] KEY_ADD    = 4'd10;
  localparam logic [3:0] KEY_SUB    = 4'd11;
  localparam logic [3:0] KEY_EQ     = 4'd12;
  localparam logic [3:0] KEY_BS     = 4'd13;
  localparam logic [3:0] KEY_CE     = 4'd14;
  localparam logic [3:0] KEY_UNUSED = 4'd15;

  // Entry controller state encoding.
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ENTER_A  = 2'd0;
  localparam logic [1:0] ENTER_B  = 2'd1;
  localparam logic [1:0] WAIT_RES = 2'd2;
  localparam logic [1:0] RESULT   = 2'd3;

  // Display stage source select.
  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  // Maximum number of digits held by one operand.
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef struct packed {
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd4_t;

  function automatic logic key_is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/bcd_operand_reg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_operand_reg
//  Purpose  : One 4-digit BCD operand register with a 0..4 digit count.
//             Commands, highest priority first:
//               zero      : value <- 0000, count <- 0
//               load      : value <- load_val, count <- 4
//               seed      : value <- 000d, count <- 1 (fresh single digit)
//               shift_in  : shift left, ones <- digit (ignored at count 4)
//               backspace : shift right, thousands <- 0 (ignored at count 0)
//  Ports    : clk, clear (sync active-high), zero, load, load_val, seed,
//             shift_in, digit, backspace -> value, count
//  Revision : 1.0  initial release
// ============================================================================
module bcd_operand_reg
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       zero,
  input  logic       load,
  input  bcd4_t      load_val,
  input  logic       seed,
  input  logic       shift_in,
  input  logic [3:0] digit,
  input  logic       backspace,
  output bcd4_t      value,
  output logic [2:0] count
);

  bcd4_t      value_d, value_q;
  logic [2:0] count_d, count_q;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (zero) begin
      value_d = '0;
      count_d = 3'd0;
    end else if (load) begin
      value_d = load_val;
      count_d = MAX_DIGITS;
    end else if (seed) begin
      value_d      = '0;
      value_d.ones = digit;
      count_d      = 3'd1;
    end else if (shift_in) begin
      if (count_q < MAX_DIGITS) begin
        value_d.thousands = value_q.hundreds;
        value_d.hundreds  = value_q.tens;
        value_d.tens      = value_q.ones;
        value_d.ones      = digit;
        count_d           = count_q + 3'd1;
      end
    end else if (backspace) begin
      if (count_q != 3'd0) begin
        value_d.thousands = 4'd0;
        value_d.hundreds  = value_q.thousands;
        value_d.tens      = value_q.hundreds;
        value_d.ones      = value_q.tens;
        count_d           = count_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      value_q <= '0;
      count_q <= 3'd0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value = value_q;
  assign count = count_q;

endmodule : bcd_operand_reg
`default_nettype wire

// File: rtl/bcd_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_entry_ctrl
//  Purpose  : Keypad entry controller for the 4-digit BCD calculator.
//             Sequences operand A, operator, operand B, result request and
//             chaining of the result back into operand A.
//  Ports    : clk, clear (sync active-high), key_valid, key_code[3:0],
//             res_{ones,tens,hundreds,thousands}[3:0]  (ALU result in)
//             num1_*[3:0], num2_*[3:0]                 (operands out)
//             op_selected (0 add / 1 sub), display_sel[1:0], result_valid
//  Revision : 1.0  initial release
// ============================================================================
module bcd_entry_ctrl
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [3:0] res_ones,
  input  logic [3:0] res_tens,
  input  logic [3:0] res_hundreds,
  input  logic [3:0] res_thousands,
  output logic [3:0] num1_ones,
  output logic [3:0] num1_tens,
  output logic [3:0] num1_hundreds,
  output logic [3:0] num1_thousands,
  output logic [3:0] num2_ones,
  output logic [3:0] num2_tens,
  output logic [3:0] num2_hundreds,
  output logic [3:0] num2_thousands,
  output logic       op_selected,
  output logic [1:0] display_sel,
  output logic       result_valid
);

  logic [STATE_W-1:0] state_d, state_q;
  logic               op_d, op_q;

  logic       w_a_zero, w_a_load, w_a_seed, w_a_shift, w_a_bs;
  logic       w_b_zero, w_b_shift, w_b_bs;
  logic       w_is_digit, w_is_op;
  bcd4_t      w_res, w_a_val, w_b_val;
  logic [2:0] w_a_cnt, w_b_cnt;

  assign w_res.thousands = res_thousands;
  assign w_res.hundreds  = res_hundreds;
  assign w_res.tens      = res_tens;
  assign w_res.ones      = res_ones;

  assign w_is_digit = key_is_digit(key_code);
  assign w_is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);

  // Control decode. Keys not named in a state (equals in ENTER_A, code 15
  // everywhere, anything in WAIT_RES) fall through with no effect.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    w_a_zero  = 1'b0;
    w_a_load  = 1'b0;
    w_a_seed  = 1'b0;
    w_a_shift = 1'b0;
    w_a_bs    = 1'b0;
    w_b_zero  = 1'b0;
    w_b_shift = 1'b0;
    w_b_bs    = 1'b0;
    case (state_q)
      ENTER_A: begin
        if (key_valid) begin
          if (w_is_digit) begin
            w_a_shift = 1'b1;
          end else if (w_is_op) begin
            op_d     = (key_code == KEY_SUB);
            w_b_zero = 1'b1;
            state_d  = ENTER_B;
          end else if (key_code == KEY_BS) begin
            w_a_bs = 1'b1;
          end else if (key_code == KEY_CE) begin
            w_a_zero = 1'b1;
          end
        end
      end
      ENTER_B: begin
        if (key_valid) begin
          if (w_is_digit) begin
            w_b_shift = 1'b1;
          end else if (w_is_op) begin
            // Operator may only be changed before any B digit is typed.
            if (w_b_cnt == 3'd0) begin
              op_d = (key_code == KEY_SUB);
            end
          end else if (key_code == KEY_EQ) begin
            state_d = WAIT_RES;
          end else if (key_code == KEY_BS) begin
            w_b_bs = 1'b1;
          end else if (key_code == KEY_CE) begin
            w_b_zero = 1'b1;
          end
        end
      end
      WAIT_RES: begin
        // One cycle for the ALU to register its result from frozen operands.
        state_d = RESULT;
      end
      RESULT: begin
        if (key_valid) begin
          if (w_is_digit) begin
            w_a_seed = 1'b1;
            w_b_zero = 1'b1;
            op_d     = 1'b0;
            state_d  = ENTER_A;
          end else if (w_is_op) begin
            // Chaining: the result becomes the new operand A.
            w_a_load = 1'b1;
            w_b_zero = 1'b1;
            op_d     = (key_code == KEY_SUB);
            state_d  = ENTER_B;
          end else if (key_code == KEY_CE) begin
            w_a_zero = 1'b1;
            w_b_zero = 1'b1;
            op_d     = 1'b0;
            state_d  = ENTER_A;
          end
        end
      end
      default: begin
        state_d = ENTER_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ENTER_A;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  bcd_operand_reg u_opnd_a (
    .clk       (clk),
    .clear     (clear),
    .zero      (w_a_zero),
    .load      (w_a_load),
    .load_val  (w_res),
    .seed      (w_a_seed),
    .shift_in  (w_a_shift),
    .digit     (key_code),
    .backspace (w_a_bs),
    .value     (w_a_val),
    .count     (w_a_cnt)
  );

  bcd_operand_reg u_opnd_b (
    .clk       (clk),
    .clear     (clear),
    .zero      (w_b_zero),
    .load      (1'b0),
    .load_val  (w_res),
    .seed      (1'b0),
    .shift_in  (w_b_shift),
    .digit     (key_code),
    .backspace (w_b_bs),
    .value     (w_b_val),
    .count     (w_b_cnt)
  );

  always_comb begin
    display_sel = DISP_RES;
    case (state_q)
      ENTER_A: display_sel = DISP_A;
      ENTER_B: display_sel = DISP_B;
      default: display_sel = DISP_RES;
    endcase
  end

  assign result_valid   = (state_q == RESULT);
  assign op_selected    = op_q;

  assign num1_thousands = w_a_val.thousands;
  assign num1_hundreds  = w_a_val.hundreds;
  assign num1_tens      = w_a_val.tens;
  assign num1_ones      = w_a_val.ones;
  assign num2_thousands = w_b_val.thousands;
  assign num2_hundreds  = w_b_val.hundreds;
  assign num2_tens      = w_b_val.tens;
  assign num2_ones      = w_b_val.ones;

endmodule : bcd_entry_ctrl
`default_nettype wire

// File: tb/tb_bcd_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_entry_ctrl
//  Purpose  : Self-checking bench for bcd_entry_ctrl. A behavioural model
//             keeps each operand as an integer plus digit count and tracks
//             the entry phase; every cycle all outputs are compared to it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_entry_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] res_ones = 4'd0, res_tens = 4'd0, res_hundreds = 4'd0, res_thousands = 4'd0;
  logic [3:0] num1_ones, num1_tens, num1_hundreds, num1_thousands;
  logic [3:0] num2_ones, num2_tens, num2_hundreds, num2_thousands;
  logic       op_selected;
  logic [1:0] display_sel;
  logic       result_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Model phases (bench-local naming).
  localparam int PH_A = 0, PH_B = 1, PH_WAIT = 2, PH_RES = 3;
  int m_a, m_a_cnt, m_b, m_b_cnt, m_op, m_ph;
  int res_val = 0;

  bcd_entry_ctrl dut (
    .clk            (clk),
    .clear          (clear),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .res_ones       (res_ones),
    .res_tens       (res_tens),
    .res_hundreds   (res_hundreds),
    .res_thousands  (res_thousands),
    .num1_ones      (num1_ones),
    .num1_tens      (num1_tens),
    .num1_hundreds  (num1_hundreds),
    .num1_thousands (num1_thousands),
    .num2_ones      (num2_ones),
    .num2_tens      (num2_tens),
    .num2_hundreds  (num2_hundreds),
    .num2_thousands (num2_thousands),
    .op_selected    (op_selected),
    .display_sel    (display_sel),
    .result_valid   (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int num1v();
    return int'(num1_thousands) * 1000 + int'(num1_hundreds) * 100 +
           int'(num1_tens) * 10 + int'(num1_ones);
  endfunction

  function automatic int num2v();
    return int'(num2_thousands) * 1000 + int'(num2_hundreds) * 100 +
           int'(num2_tens) * 10 + int'(num2_ones);
  endfunction

  task automatic model_reset();
    m_a = 0; m_a_cnt = 0; m_b = 0; m_b_cnt = 0; m_op = 0; m_ph = PH_A;
  endtask

  // Digit entry on an integer operand: append while fewer than 4 digits.
  task automatic edit(inout int val, inout int cnt, input int code);
    if (code <= 9) begin
      if (cnt < 4) begin val = val * 10 + code; cnt++; end
    end else if (code == 13) begin
      if (cnt > 0) begin val = val / 10; cnt--; end
    end else if (code == 14) begin
      val = 0; cnt = 0;
    end
  endtask

  task automatic model_step(input bit kv, input int code, input bit clr);
    if (clr) begin
      model_reset();
    end else if (m_ph == PH_WAIT) begin
      m_ph = PH_RES;
    end else if (kv) begin
      case (m_ph)
        PH_A: begin
          if (code == 10 || code == 11) begin
            m_op = (code == 11); m_b = 0; m_b_cnt = 0; m_ph = PH_B;
          end else edit(m_a, m_a_cnt, code);
        end
        PH_B: begin
          if (code == 10 || code == 11) begin
            if (m_b_cnt == 0) m_op = (code == 11);
          end else if (code == 12) m_ph = PH_WAIT;
          else edit(m_b, m_b_cnt, code);
        end
        default: begin
          if (code <= 9) begin
            m_a = code; m_a_cnt = 1; m_b = 0; m_b_cnt = 0; m_op = 0; m_ph = PH_A;
          end else if (code == 10 || code == 11) begin
            m_a = res_val; m_a_cnt = 4; m_b = 0; m_b_cnt = 0;
            m_op = (code == 11); m_ph = PH_B;
          end else if (code == 14) begin
            model_reset();
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("num1", num1v(), m_a);
    check("num2", num2v(), m_b);
    check("op_selected", int'(op_selected), m_op);
    check("display_sel", int'(display_sel), (m_ph == PH_A) ? 0 : (m_ph == PH_B) ? 1 : 2);
    check("result_valid", int'(result_valid), (m_ph == PH_RES) ? 1 : 0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check #1 later.
  task automatic step(input bit kv, input int code, input bit clr);
    key_valid     = kv;
    key_code      = 4'(code);
    clear         = clr;
    res_thousands = 4'(res_val / 1000);
    res_hundreds  = 4'((res_val / 100) % 10);
    res_tens      = 4'((res_val / 10) % 10);
    res_ones      = 4'(res_val % 10);
    @(posedge clk);
    model_step(kv, code, clr);
    #1;
    key_valid = 1'b0;
    clear     = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    step(0, 0, 1);
    check("reset_num1", num1v(), 0);
    check("reset_disp", int'(display_sel), 0);

    // 1,2,3 -> A = 0123
    step(1, 1, 0); step(1, 2, 0); step(1, 3, 0);
    check("tp_a123", num1v(), 123);

    // Fifth digit ignored, then backspace.
    step(0, 0, 1);
    step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 4, 0); step(1, 5, 0);
    check("tp_a1234", num1v(), 1234);
    step(1, 13, 0);
    check("tp_bs", num1v(), 123);

    // 7 SUB 4 5 EQ, key during WAIT_RES dropped, then chain ADD with 0168.
    step(0, 0, 1);
    step(1, 7, 0); step(1, 11, 0); step(1, 4, 0); step(1, 5, 0);
    step(1, 12, 0);
    check("tp_wait_disp", int'(display_sel), 2);
    check("tp_wait_rv", int'(result_valid), 0);
    step(1, 9, 0);
    check("tp_res_rv", int'(result_valid), 1);
    check("tp_b45", num2v(), 45);
    res_val = 168;
    step(1, 10, 0);
    check("tp_chain_a", num1v(), 168);
    check("tp_chain_op", int'(op_selected), 0);

    // Operator change only with empty B.
    step(1, 9, 0); step(1, 11, 0);
    check("tp_op_locked", int'(op_selected), 0);
    step(1, 14, 0); step(1, 11, 0);
    check("tp_op_change", int'(op_selected), 1);

    // Clear wins over a simultaneous digit.
    step(0, 0, 1);
    step(1, 4, 0); step(1, 2, 0);
    step(1, 5, 1);
    check("tp_clear_prio", num1v(), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      res_val = $urandom_range(0, 9999);
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 15), ($urandom_range(0, 149) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bcd_entry_ctrl
`default_nettype wire
